// File: rtl/sm4_pkg.sv
// -----------------------------------------------------------------------------
// sm4_pkg
// Shared definitions for the serial SM4 tau/linear-transform controller:
//   - state encoding of the byte-serial controller FSM
//   - rotation amounts of the SM4 linear transforms L (round) and L' (key exp.)
//   - small helpers: 32-bit rotate-left, byte extract and byte insert
// -----------------------------------------------------------------------------
package sm4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LIN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // L(B)  = B ^ rol(B,2) ^ rol(B,10) ^ rol(B,18) ^ rol(B,24)
  localparam int unsigned L_ROT_0  = 2;
  localparam int unsigned L_ROT_1  = 10;
  localparam int unsigned L_ROT_2  = 18;
  localparam int unsigned L_ROT_3  = 24;
  // L'(B) = B ^ rol(B,13) ^ rol(B,23)
  localparam int unsigned LP_ROT_0 = 13;
  localparam int unsigned LP_ROT_1 = 23;

  // Rotate left by n (only n mod 32 matters; n = 0 returns x unchanged).
  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
    logic [4:0] s;
    s = 5'(n);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  // Byte idx of a word, idx 3 = MSB.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Replace byte idx of a word with b.
  function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sm4_lin.sv
// -----------------------------------------------------------------------------
// sm4_lin
// Combinational SM4 linear transform applied to a single share.
//   mode = 0 : L  (round function)
//   mode = 1 : L' (key expansion)
// Ports:
//   mode  in   1   transform select
//   din   in  32   input word (one share)
//   dout  out 32   transformed word
// Both transforms are linear over GF(2), so applying them per share keeps the
// XOR sharing valid without ever combining the shares.
// -----------------------------------------------------------------------------
module sm4_lin
  import sm4_pkg::*;
(
  input  logic        mode,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] l_out;
  logic [31:0] lp_out;

  assign l_out  = din ^ rol32(din, L_ROT_0) ^ rol32(din, L_ROT_1)
                      ^ rol32(din, L_ROT_2) ^ rol32(din, L_ROT_3);
  assign lp_out = din ^ rol32(din, LP_ROT_0) ^ rol32(din, LP_ROT_1);
  assign dout   = mode ? lp_out : l_out;

endmodule

// File: rtl/sm4_tau_serial.sv
// -----------------------------------------------------------------------------
// sm4_tau_serial
// Byte-serial initiator for an external masked SM4 S-box engine. A 32-bit word
// arrives as two XOR shares; its four bytes (MSB first) are sent one at a time
// through the single shared S-box using a start/finish handshake, the returned
// shares are collected, and L or L' is applied to each share separately.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input word handshake (ready only in IDLE)
//   in_sh1, in_sh0        input word shares; mode 0 = L, 1 = L'
//   sb_start              one-cycle start pulse to the S-box
//   sb_x, sb_m            share-1 / share-0 byte to the S-box (held until finish)
//   sb_finish             S-box done pulse, sb_out1/sb_out0 valid with it
//   out_valid/out_ready   result handshake
//   out_sh1, out_sh0      result shares (held while out_valid)
//   err                   one-cycle pulse when the S-box does not answer in time
//
// Timing: sb_start is high during the START cycle; with S-box latency Ls the
// word takes 4*(Ls+1)+2 cycles from acceptance to out_valid.
// -----------------------------------------------------------------------------
module sm4_tau_serial
  import sm4_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_sh1,
  input  logic [31:0] in_sh0,
  input  logic        mode,
  output logic        sb_start,
  output logic [7:0]  sb_x,
  output logic [7:0]  sb_m,
  input  logic        sb_finish,
  input  logic [7:0]  sb_out1,
  input  logic [7:0]  sb_out0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sh1,
  output logic [31:0] out_sh0,
  output logic        err
);

  state_t      state_q,     state_d;
  logic [31:0] sh1_q,       sh1_d;
  logic [31:0] sh0_q,       sh0_d;
  logic [31:0] acc1_q,      acc1_d;
  logic [31:0] acc0_q,      acc0_d;
  logic        mode_q,      mode_d;
  logic [1:0]  idx_q,       idx_d;
  logic [TW-1:0] cnt_q,     cnt_d;
  logic        sb_start_q,  sb_start_d;
  logic [7:0]  sb_x_q,      sb_x_d;
  logic [7:0]  sb_m_q,      sb_m_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_sh1_q,   out_sh1_d;
  logic [31:0] out_sh0_q,   out_sh0_d;
  logic        err_q,       err_d;

  logic [31:0] lin1;
  logic [31:0] lin0;

  // One transform instance per share; the shares never meet.
  sm4_lin u_lin1 (
    .mode (mode_q),
    .din  (acc1_q),
    .dout (lin1)
  );

  sm4_lin u_lin0 (
    .mode (mode_q),
    .din  (acc0_q),
    .dout (lin0)
  );

  // The timeout counter holds the number of cycles since sb_start was raised:
  // it is 0 in the START cycle, so hitting TIMEOUT-1 in WAIT puts err on the
  // wire exactly TIMEOUT cycles after the start pulse.
  always_comb begin
    // NOTE: every signal assigned below gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    sh1_d       = sh1_q;
    sh0_d       = sh0_q;
    acc1_d      = acc1_q;
    acc0_d      = acc0_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    sb_start_d  = 1'b0;
    sb_x_d      = sb_x_q;
    sb_m_d      = sb_m_q;
    out_valid_d = out_valid_q;
    out_sh1_d   = out_sh1_q;
    out_sh0_d   = out_sh0_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh1_d      = in_sh1;
          sh0_d      = in_sh0;
          mode_d     = mode;
          idx_d      = 2'd3;
          acc1_d     = '0;
          acc0_d     = '0;
          // Byte 3 is presented straight from the input so the start pulse
          // and its operands appear together in the START cycle.
          sb_x_d     = in_sh1[31:24];
          sb_m_d     = in_sh0[31:24];
          sb_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        cnt_d   = cnt_q + TW'(1);
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A finish arriving in the timeout cycle still completes the byte.
        if (sb_finish) begin
          acc1_d = set_byte(acc1_q, idx_q, sb_out1);
          acc0_d = set_byte(acc0_q, idx_q, sb_out0);
          if (idx_q == 2'd0) begin
            state_d = ST_LIN;
          end else begin
            idx_d      = idx_q - 2'd1;
            sb_x_d     = byte_of(sh1_q, idx_q - 2'd1);
            sb_m_d     = byte_of(sh0_q, idx_q - 2'd1);
            sb_start_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_START;
          end
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          // Abort: drop the partial word so no share material lingers.
          err_d   = 1'b1;
          sh1_d   = '0;
          sh0_d   = '0;
          acc1_d  = '0;
          acc0_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          sb_x_d  = '0;
          sb_m_d  = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      ST_LIN: begin
        out_sh1_d   = lin1;
        out_sh0_d   = lin0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh1_q       <= '0;
      sh0_q       <= '0;
      acc1_q      <= '0;
      acc0_q      <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      sb_start_q  <= 1'b0;
      sb_x_q      <= '0;
      sb_m_q      <= '0;
      out_valid_q <= 1'b0;
      out_sh1_q   <= '0;
      out_sh0_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh1_q       <= sh1_d;
      sh0_q       <= sh0_d;
      acc1_q      <= acc1_d;
      acc0_q      <= acc0_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      sb_start_q  <= sb_start_d;
      sb_x_q      <= sb_x_d;
      sb_m_q      <= sb_m_d;
      out_valid_q <= out_valid_d;
      out_sh1_q   <= out_sh1_d;
      out_sh0_q   <= out_sh0_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign sb_start  = sb_start_q;
  assign sb_x      = sb_x_q;
  assign sb_m      = sb_m_q;
  assign out_valid = out_valid_q;
  assign out_sh1   = out_sh1_q;
  assign out_sh0   = out_sh0_q;
  assign err       = err_q;

endmodule
